// File: rtl/reg_wb_pkg.sv
// Shared constants and source encoding for the register-file writeback arbiter.
package reg_wb_pkg;

   localparam int WORD_SIZE = 16;
   localparam int ADDR_SIZE = 4;
   localparam int MEM_SIZE  = 16;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_M = 1'b1
   } src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is the ALU source, bit 1 the memory source.
// The LAST pointer starts at the memory source so the ALU wins the first tie.
module rr_arb2
   import reg_wb_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   output logic [1:0] o_gnt
);

   src_e r_last;

   // Grant decode from requests and the last-served pointer.
   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = (r_last == SRC_M) ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

   // Pointer moves to the granted source on every transfer and holds when idle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last <= SRC_M;
      end else if (i_advance && (o_gnt != 2'b00)) begin
         r_last <= o_gnt[1] ? SRC_M : SRC_A;
      end else begin
         r_last <= r_last;
      end
   end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter for the 16x16 register file: round-robin between ALU and memory
// results, registered write port, pending-write scoreboard and sticky protocol error.
// Optional macro REG_WB_ZERO_LOCK_EN hardwires register 0.
module reg_wb_arbiter
   import reg_wb_pkg::*;
#(
   parameter int WORD_SIZE = reg_wb_pkg::WORD_SIZE,
   parameter int ADDR_SIZE = reg_wb_pkg::ADDR_SIZE,
   parameter int MEM_SIZE  = reg_wb_pkg::MEM_SIZE
)
(
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 RSV_VALID,
   input  logic [ADDR_SIZE-1:0] RSV_ADDR,
   input  logic                 A_VALID,
   input  logic [ADDR_SIZE-1:0] A_ADDR,
   input  logic [WORD_SIZE-1:0] A_DATA,
   output logic                 A_READY,
   input  logic                 M_VALID,
   input  logic [ADDR_SIZE-1:0] M_ADDR,
   input  logic [WORD_SIZE-1:0] M_DATA,
   output logic                 M_READY,
   output logic                 W_ON,
   output logic [ADDR_SIZE-1:0] WADDR,
   output logic [WORD_SIZE-1:0] DATA_IN,
   output logic [MEM_SIZE-1:0]  PEND,
   output logic                 ERR
);

   logic [1:0]           w_gnt;
   logic                 w_xfer;
   logic [ADDR_SIZE-1:0] w_addr;
   logic [WORD_SIZE-1:0] w_data;
   logic                 w_zero_wr;
   logic                 w_rsv_ok;
   logic                 w_wr_en;
   logic                 w_err_hit;
   logic [MEM_SIZE-1:0]  w_pend_nxt;

   logic                 r_w_on;
   logic [ADDR_SIZE-1:0] r_waddr;
   logic [WORD_SIZE-1:0] r_data;
   logic [MEM_SIZE-1:0]  r_pend;
   logic                 r_err;

   rr_arb2 u_arb (
      .i_clk     (CLK),
      .i_rst_n   (RST_N),
      .i_req     ({M_VALID, A_VALID}),
      .i_advance (w_xfer),
      .o_gnt     (w_gnt)
   );

   assign A_READY = w_gnt[0];
   assign M_READY = w_gnt[1];
   assign w_xfer  = |w_gnt;
   assign w_addr  = w_gnt[1] ? M_ADDR : A_ADDR;
   assign w_data  = w_gnt[1] ? M_DATA : A_DATA;

`ifdef REG_WB_ZERO_LOCK_EN
   // Register 0 is hardwired: its writes still handshake but never reach the file.
   assign w_zero_wr = (w_addr == {ADDR_SIZE{1'b0}});
   assign w_rsv_ok  = RSV_VALID && (RSV_ADDR != {ADDR_SIZE{1'b0}});
`else
   assign w_zero_wr = 1'b0;
   assign w_rsv_ok  = RSV_VALID;
`endif

   assign w_wr_en   = w_xfer && !w_zero_wr;
   assign w_err_hit = w_wr_en && !r_pend[w_addr];

   // Scoreboard update: clear the address written last cycle, then apply the new
   // reservation so a same-address set wins over the clear.
   always_comb begin
      w_pend_nxt = r_pend;
      if (r_w_on) begin
         w_pend_nxt[r_waddr] = 1'b0;
      end else begin
         w_pend_nxt = r_pend;
      end
      if (w_rsv_ok) begin
         w_pend_nxt[RSV_ADDR] = 1'b1;
      end else begin
         w_pend_nxt[0] = w_pend_nxt[0];
      end
`ifdef REG_WB_ZERO_LOCK_EN
      w_pend_nxt[0] = 1'b0;
`endif
   end

   // Registered write port, scoreboard and sticky error flag.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_w_on  <= 1'b0;
         r_waddr <= {ADDR_SIZE{1'b0}};
         r_data  <= {WORD_SIZE{1'b0}};
         r_pend  <= {MEM_SIZE{1'b0}};
         r_err   <= 1'b0;
      end else begin
         r_w_on <= w_wr_en;
         if (w_wr_en) begin
            r_waddr <= w_addr;
            r_data  <= w_data;
         end else begin
            r_waddr <= r_waddr;
            r_data  <= r_data;
         end
         r_pend <= w_pend_nxt;
         r_err  <= r_err || w_err_hit;
      end
   end

   assign W_ON    = r_w_on;
   assign WADDR   = r_waddr;
   assign DATA_IN = r_data;
   assign PEND    = r_pend;
   assign ERR     = r_err;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed self-checking bench for reg_wb_arbiter with a negedge-write register file model.
// Covers reset, single source, contention, backpressure, scoreboard collision, error and register 0.
`timescale 1ns/1ps
module tb_reg_wb_arbiter;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        RSV_VALID;
   logic [3:0]  RSV_ADDR;
   logic        A_VALID;
   logic [3:0]  A_ADDR;
   logic [15:0] A_DATA;
   logic        A_READY;
   logic        M_VALID;
   logic [3:0]  M_ADDR;
   logic [15:0] M_DATA;
   logic        M_READY;
   logic        W_ON;
   logic [3:0]  WADDR;
   logic [15:0] DATA_IN;
   logic [15:0] PEND;
   logic        ERR;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [15:0] rf [16]     = '{default: 16'h0000};
   int          wr_cnt [16] = '{default: 0};
   int          cnt7;

   reg_wb_arbiter dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .RSV_VALID (RSV_VALID),
      .RSV_ADDR  (RSV_ADDR),
      .A_VALID   (A_VALID),
      .A_ADDR    (A_ADDR),
      .A_DATA    (A_DATA),
      .A_READY   (A_READY),
      .M_VALID   (M_VALID),
      .M_ADDR    (M_ADDR),
      .M_DATA    (M_DATA),
      .M_READY   (M_READY),
      .W_ON      (W_ON),
      .WADDR     (WADDR),
      .DATA_IN   (DATA_IN),
      .PEND      (PEND),
      .ERR       (ERR)
   );

   always #5 CLK = ~CLK;

   // Register file model: writes on the falling edge while the write enable is high.
   always @(negedge CLK) begin
      if (RST_N && W_ON) begin
         rf[WADDR]     <= DATA_IN;
         wr_cnt[WADDR] <= wr_cnt[WADDR] + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic rst_pulse();
      RST_N = 1'b0;
      #2;
      RST_N = 1'b1;
   endtask

   task automatic reserve(input logic [3:0] addr);
      RSV_VALID = 1'b1;
      RSV_ADDR  = addr;
      tick();
      RSV_VALID = 1'b0;
   endtask

   initial begin
      RST_N = 1'b0;
      RSV_VALID = 1'b0; RSV_ADDR = 4'd0;
      A_VALID = 1'b0; A_ADDR = 4'd0; A_DATA = 16'h0000;
      M_VALID = 1'b0; M_ADDR = 4'd0; M_DATA = 16'h0000;

      // Reset state
      repeat (2) tick();
      check("rst_won",  W_ON,    32'd0);
      check("rst_wadr", WADDR,   32'd0);
      check("rst_data", DATA_IN, 32'd0);
      check("rst_pend", PEND,    32'd0);
      check("rst_err",  ERR,     32'd0);
      check("rst_rdy",  {A_READY, M_READY}, 32'd0);
      RST_N = 1'b1;
      tick();

      // Single source
      reserve(4'd5);
      check("ss_pend5", PEND[5], 32'd1);
      A_VALID = 1'b1; A_ADDR = 4'd5; A_DATA = 16'h1234;
      #1;
      check("ss_ardy", A_READY, 32'd1);
      check("ss_mrdy", M_READY, 32'd0);
      tick();
      A_VALID = 1'b0;
      check("ss_won",  W_ON,    32'd1);
      check("ss_wadr", WADDR,   32'd5);
      check("ss_data", DATA_IN, 32'h1234);
      tick();
      check("ss_won0",  W_ON,    32'd0);
      check("ss_pclr",  PEND[5], 32'd0);
      check("ss_rf5",   rf[5],   32'h1234);
      check("ss_err",   ERR,     32'd0);

      // Contention from a fresh pointer: A,M,A,M
      rst_pulse();
      for (int i = 1; i <= 4; i++) reserve(4'(i));
      check("ct_pend", PEND, 32'h001E);
      A_VALID = 1'b1; A_ADDR = 4'd1; A_DATA = 16'h1111;
      M_VALID = 1'b1; M_ADDR = 4'd2; M_DATA = 16'h2222;
      #1;
      check("ct_g0", {M_READY, A_READY}, 32'b01);
      tick();
      check("ct_w0", {W_ON, WADDR, DATA_IN}, {11'd0, 1'b1, 4'd1, 16'h1111});
      A_ADDR = 4'd3; A_DATA = 16'h3333;
      #1;
      check("ct_g1", {M_READY, A_READY}, 32'b10);
      tick();
      check("ct_w1", {W_ON, WADDR, DATA_IN}, {11'd0, 1'b1, 4'd2, 16'h2222});
      M_ADDR = 4'd4; M_DATA = 16'h4444;
      #1;
      check("ct_g2", {M_READY, A_READY}, 32'b01);
      tick();
      check("ct_w2", {W_ON, WADDR, DATA_IN}, {11'd0, 1'b1, 4'd3, 16'h3333});
      A_VALID = 1'b0;
      #1;
      check("ct_g3", {M_READY, A_READY}, 32'b10);
      tick();
      check("ct_w3", {W_ON, WADDR, DATA_IN}, {11'd0, 1'b1, 4'd4, 16'h4444});
      M_VALID = 1'b0;
      tick();
      check("ct_idle", W_ON, 32'd0);
      check("ct_pend0", PEND, 32'd0);
      check("ct_err",  ERR,  32'd0);

      // Backpressure: last grant was M, so A wins and M waits one cycle
      reserve(4'd7);
      reserve(4'd8);
      cnt7 = wr_cnt[7];
      A_VALID = 1'b1; A_ADDR = 4'd8; A_DATA = 16'h8888;
      M_VALID = 1'b1; M_ADDR = 4'd7; M_DATA = 16'hBEEF;
      #1;
      check("bp_mwait", M_READY, 32'd0);
      tick();
      check("bp_wadr8", WADDR, 32'd8);
      A_VALID = 1'b0;
      #1;
      check("bp_mrdy", M_READY, 32'd1);
      tick();
      check("bp_w7", {W_ON, WADDR, DATA_IN}, {11'd0, 1'b1, 4'd7, 16'hBEEF});
      M_VALID = 1'b0;
      tick();
      check("bp_nodup", W_ON, 32'd0);
      check("bp_cnt7",  wr_cnt[7] - cnt7, 32'd1);
      check("bp_rf7",   rf[7], 32'hBEEF);
      check("bp_pend0", PEND, 32'd0);

      // Set/clear collision: same address keeps the bit, different addresses both apply
      reserve(4'd6);
      A_VALID = 1'b1; A_ADDR = 4'd6; A_DATA = 16'h6666;
      tick();
      A_VALID = 1'b0;
      reserve(4'd6);
      check("col_same", PEND, 32'h0040);
      reserve(4'd10);
      A_VALID = 1'b1; A_ADDR = 4'd10; A_DATA = 16'hAAAA;
      tick();
      A_VALID = 1'b0;
      reserve(4'd11);
      check("col_diff", PEND, 32'h0840);

      // Error: write to a register that was never reserved
      A_VALID = 1'b1; A_ADDR = 4'd9; A_DATA = 16'h9999;
      tick();
      A_VALID = 1'b0;
      check("err_set",  ERR, 32'd1);
      check("err_wr",   {W_ON, WADDR}, {27'd0, 1'b1, 4'd9});
      repeat (3) tick();
      check("err_stky", ERR, 32'd1);
      check("err_rf9",  rf[9], 32'h9999);

      // Mid-cycle reset with a write in flight
      reserve(4'd5);
      A_VALID = 1'b1; A_ADDR = 4'd5; A_DATA = 16'h5555;
      tick();
      A_VALID = 1'b0;
      check("mr_pre", W_ON, 32'd1);
      #1;
      RST_N = 1'b0;
      #1;
      check("mr_won",  W_ON, 32'd0);
      check("mr_pend", PEND, 32'd0);
      check("mr_err",  ERR,  32'd0);
      #4;
      check("mr_nowr", rf[5], 32'h1234);
      RST_N = 1'b1;
      tick();

      // Register 0
`ifdef REG_WB_ZERO_LOCK_EN
      reserve(4'd0);
      check("z_pend0", PEND[0], 32'd0);
      A_VALID = 1'b1; A_ADDR = 4'd0; A_DATA = 16'h0ABC;
      #1;
      check("z_ardy", A_READY, 32'd1);
      tick();
      A_VALID = 1'b0;
      check("z_won", W_ON, 32'd0);
      check("z_err", ERR,  32'd0);
      tick();
      check("z_rf0", rf[0], 32'h0000);
`else
      reserve(4'd0);
      check("z_pend0", PEND[0], 32'd1);
      A_VALID = 1'b1; A_ADDR = 4'd0; A_DATA = 16'h0ABC;
      #1;
      check("z_ardy", A_READY, 32'd1);
      tick();
      A_VALID = 1'b0;
      check("z_won", {W_ON, WADDR}, {27'd0, 1'b1, 4'd0});
      check("z_err", ERR, 32'd0);
      tick();
      check("z_rf0",   rf[0],   32'h0ABC);
      check("z_pclr",  PEND[0], 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the single write port of the 16x16 register file between two writeback sources: ALU result (A) and load/memory result (M).
- Round-robin arbitration with a valid/ready handshake; exactly one registered write per cycle is driven onto W_ON/WADDR/DATA_IN.
- Keeps a pending-write scoreboard (PEND). Decode reserves a destination at issue and stalls on pending sources; the bit clears once the write has landed.

Parameters:
- WORD_SIZE, 16, data width of the register file.
- ADDR_SIZE, 4, register address width.
- MEM_SIZE, 16, number of registers (= 2**ADDR_SIZE).

Ports:
- CLK  in  1  clock; all state changes on posedge. The register file writes on negedge.
- RST_N  in  1  asynchronous, active-low reset.
- RSV_VALID  in  1  issue stage reserves destination RSV_ADDR this cycle.
- RSV_ADDR  in  ADDR_SIZE  register being reserved.
- A_VALID  in  1  ALU writeback request.
- A_ADDR  in  ADDR_SIZE  ALU destination register.
- A_DATA  in  WORD_SIZE  ALU result.
- A_READY  out  1  ALU request granted this cycle (combinational).
- M_VALID  in  1  memory writeback request.
- M_ADDR  in  ADDR_SIZE  memory destination register.
- M_DATA  in  WORD_SIZE  load data.
- M_READY  out  1  memory request granted this cycle (combinational).
- W_ON  out  1  register file write enable (registered).
- WADDR  out  ADDR_SIZE  register file write address (registered).
- DATA_IN  out  WORD_SIZE  register file write data (registered).
- PEND  out  MEM_SIZE  pending-write scoreboard; bit i = register i awaiting writeback.
- ERR  out  1  sticky protocol error flag.

Behaviour:
- Reset (async, RST_N=0):
  - W_ON=0, WADDR=0, DATA_IN=0, PEND=0, ERR=0.
  - Round-robin pointer LAST=M, so A wins the first tie.
  - A write in flight is dropped: W_ON falls asynchronously, so no negedge write occurs.
- Handshake:
  - A transfer occurs when VALID && READY at posedge.
  - Once VALID is asserted, the source holds ADDR/DATA stable until READY.
  - READY never depends on the other source's data.
- Arbitration (combinational from VALIDs and LAST):
  - Only A valid -> A_READY=1.
  - Only M valid -> M_READY=1.
  - Both valid -> grant the source not equal to LAST.
  - Neither valid -> both READY=0.
  - LAST updates to the granted source on each transfer; it holds when idle.
- Output register, posedge k:
  - Transfer -> W_ON=1 and WADDR/DATA_IN = winner's ADDR/DATA.
  - No transfer -> W_ON=0, WADDR/DATA_IN hold.
  - The register file writes at the negedge of cycle k. Combinational reads see the new value from that negedge on.
- Scoreboard:
  - On posedge where RSV_VALID: PEND[RSV_ADDR] <= 1.
  - On posedge where W_ON==1 (write already landed at the previous negedge): PEND[WADDR] <= 0.
  - The clear is therefore one cycle after acceptance. This guarantees that any register reading PEND=0 already holds the final data.
  - Set and clear to the same address on the same edge -> set wins (back-to-back reservation).
  - Set and clear to different addresses on the same edge -> both apply.
- ERR: set sticky when a transfer is accepted for an address whose PEND bit is 0 on that edge. Cleared only by reset. The write still proceeds.
- Throughput: one write per cycle sustained. With both sources continuously valid, grants alternate A,M,A,M; there is no starvation.

Optional Feature:
- Macro REG_WB_ZERO_LOCK_EN.
- Defined:
  - Register 0 is hardwired. Requests to address 0 still handshake (READY per arbitration), but W_ON stays 0 for them.
  - RSV to address 0 is ignored, PEND[0] is constant 0, and writes to 0 never raise ERR.
- Undefined: register 0 behaves as any other register.

Decomposition:
- Package reg_wb_pkg:
  - WORD_SIZE, ADDR_SIZE and MEM_SIZE constants.
  - Source enum: SRC_A=1'b0, SRC_M=1'b1.
- One sub-module rr_arb2:
  - 2-requester round-robin arbiter with a LAST pointer.
  - Inputs: req[1:0], advance. Outputs: gnt[1:0].
  - The top level holds the output register, scoreboard and ERR logic.

Test Plan:
- Reset: RST_N=0 mid-cycle with W_ON=1 -> W_ON, PEND, ERR all 0 immediately; no register file write at next negedge.
- Single source: RSV r5; A_VALID, A_ADDR=5, A_DATA=16'h1234 -> A_READY=1; next edge W_ON=1, WADDR=5, DATA_IN=16'h1234; one edge later PEND[5]=0; reg 5 reads 16'h1234.
- Contention: RSV r1,r2,r3,r4; A and M held valid for 4 cycles (A to r1,r3; M to r2,r4) -> grant order A,M,A,M; PEND ends 0; ERR=0.
- Backpressure hold: A and M valid; M waits one cycle with stable M_ADDR=7, M_DATA=16'hBEEF -> written exactly once; no duplicate W_ON.
- Set/clear collision: W_ON=1 for r6 while RSV_VALID r6 -> PEND[6] remains 1.
- Error/zero: A writes r9 with PEND[9]=0 -> ERR=1 sticky until reset. Write to r0 with REG_WB_ZERO_LOCK_EN -> A_READY=1, W_ON=0, ERR=0.
